// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares a single UART transmitter between NUM_REQ requesters. A round-robin
//   arbiter picks one request at a time. Each request is sent as one or two bytes,
//   low byte first. Bytes are paced by the UART Busy flag, and a missing Busy rise
//   causes the byte to be retried.
//
// Ports
//   CLK         rising-edge clock
//   Reset       asynchronous, active-low reset
//   Req         per-requester request level, held until the matching Req_done
//   Req_len     per-requester length: 0 = 1 byte, 1 = 2 bytes
//   Req_data    per-requester 16-bit payload, slice i = [16*i+15:16*i]
//   Tx_busy     UART transmitter Busy flag
//   Tx_data     byte to the UART, held stable while the UART shifts it out
//   Tx_valid    single-cycle Data_valid pulse to the UART
//   Req_grant   one-hot grant, high for the whole transaction
//   Req_done    one-hot single-cycle pulse after the last byte has finished
//   Sched_busy  high whenever the scheduler is not idle
//   Err_timeout single-cycle pulse when Busy did not rise in time
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     Req,
  input  logic [NUM_REQ-1:0]     Req_len,
  input  logic [16*NUM_REQ-1:0]  Req_data,
  input  logic                   Tx_busy,
  output logic [7:0]             Tx_data,
  output logic                   Tx_valid,
  output logic [NUM_REQ-1:0]     Req_grant,
  output logic [NUM_REQ-1:0]     Req_done,
  output logic                   Sched_busy,
  output logic                   Err_timeout
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitRise,
    StWaitFall,
    StNext
  } state_e;

  state_e             state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [PtrW-1:0]    win_q, win_d;
  logic [15:0]        data_q, data_d;
  logic               len_q, len_d;
  logic               second_q, second_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               sched_q, sched_d;
  logic               err_q, err_d;

  logic               arb_found;
  logic [PtrW-1:0]    arb_idx;
  logic [PtrW-1:0]    cand;
  int unsigned        sum;
  logic [15:0]        sel_data;
  logic               sel_len;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PtrW-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      oh[i] = (idx == PtrW'(i));
    end
    return oh;
  endfunction

  // Round-robin search starting just after the last winner, wrapping to 0.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      sum = 32'(ptr_q) + i;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = PtrW'(sum);
      if (!arb_found && Req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Payload and length of the current arbitration winner.
  always_comb begin
    sel_data = '0;
    sel_len  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == PtrW'(i)) begin
        sel_data = Req_data[16*i +: 16];
        sel_len  = Req_len[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    data_d     = data_q;
    len_d      = len_q;
    second_d   = second_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|Req) begin
          state_d = StLoad;
        end
      end

      StLoad: begin
        if (arb_found) begin
          win_d     = arb_idx;
          data_d    = sel_data;
          len_d     = sel_len;
          second_d  = 1'b0;
          grant_d   = onehot(arb_idx);
          tx_data_d = sel_data[7:0];
          state_d   = StSend;
        end else begin
          // Request withdrawn before it could be latched.
          state_d = StIdle;
        end
      end

      StSend: begin
        tx_valid_d = 1'b1;
        cnt_d      = '0;
        state_d    = StWaitRise;
      end

      StWaitRise: begin
        // A Busy that is still high from earlier also counts as the rise.
        if (Tx_busy) begin
          state_d = StWaitFall;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StSend;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWaitFall: begin
        if (!Tx_busy) begin
          state_d = StNext;
        end
      end

      StNext: begin
        if (len_q && !second_q) begin
          second_d  = 1'b1;
          tx_data_d = data_q[15:8];
          state_d   = StSend;
        end else begin
          done_d  = onehot(win_q);
          grant_d = '0;
          ptr_d   = win_q;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    sched_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      ptr_q      <= PtrW'(NUM_REQ - 1);
      win_q      <= '0;
      data_q     <= '0;
      len_q      <= 1'b0;
      second_q   <= 1'b0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      sched_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      data_q     <= data_d;
      len_q      <= len_d;
      second_q   <= second_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      sched_q    <= sched_d;
      err_q      <= err_d;
    end
  end

  assign Tx_data     = tx_data_q;
  assign Tx_valid    = tx_valid_q;
  assign Req_grant   = grant_q;
  assign Req_done    = done_q;
  assign Sched_busy  = sched_q;
  assign Err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler (NUM_REQ = 2, BUSY_TIMEOUT = 8).
//   Busy is driven by hand from the stimulus sequence. Outputs are sampled on
//   the falling clock edge.
module tb_uart_tx_scheduler;

  localparam int unsigned NumReq      = 2;
  localparam int unsigned BusyTimeout = 8;

  logic                  CLK;
  logic                  Reset;
  logic [NumReq-1:0]     Req;
  logic [NumReq-1:0]     Req_len;
  logic [16*NumReq-1:0]  Req_data;
  logic                  Tx_busy;
  logic [7:0]            Tx_data;
  logic                  Tx_valid;
  logic [NumReq-1:0]     Req_grant;
  logic [NumReq-1:0]     Req_done;
  logic                  Sched_busy;
  logic                  Err_timeout;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_scheduler #(
    .NUM_REQ      (NumReq),
    .BUSY_TIMEOUT (BusyTimeout)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Req         (Req),
    .Req_len     (Req_len),
    .Req_data    (Req_data),
    .Tx_busy     (Tx_busy),
    .Tx_data     (Tx_data),
    .Tx_valid    (Tx_valid),
    .Req_grant   (Req_grant),
    .Req_done    (Req_done),
    .Sched_busy  (Sched_busy),
    .Err_timeout (Err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at the falling edge just before the edge on which the IDLE state sees Req.
  // Runs one whole transaction and returns at the falling edge where Req_done is visible.
  // When scramble is set, it corrupts payload/length and drops Req right after LOAD.
  task automatic serve(input logic [NumReq-1:0] g, input logic two, input logic [7:0] lo,
                       input logic [7:0] hi, input logic scramble, input string tag);
    @(negedge CLK);
    check({tag, "_load_busy"}, 32'(Sched_busy), 32'd1);
    check({tag, "_load_nogrant"}, 32'(Req_grant), 32'd0);
    @(negedge CLK);
    check({tag, "_grant"}, 32'(Req_grant), 32'(g));
    check({tag, "_lo"}, 32'(Tx_data), 32'(lo));
    check({tag, "_pre_valid"}, 32'(Tx_valid), 32'd0);
    if (scramble) begin
      Req_data = ~Req_data;
      Req_len  = ~Req_len;
      Req      = '0;
    end
    @(negedge CLK);
    check({tag, "_valid1"}, 32'(Tx_valid), 32'd1);
    check({tag, "_lo_at_valid"}, 32'(Tx_data), 32'(lo));
    Tx_busy = 1'b1;
    @(negedge CLK);
    check({tag, "_valid1_pulse"}, 32'(Tx_valid), 32'd0);
    @(negedge CLK);
    check({tag, "_lo_held"}, 32'(Tx_data), 32'(lo));
    Tx_busy = 1'b0;
    @(negedge CLK);
    check({tag, "_next_nodone"}, 32'(Req_done), 32'd0);
    if (two) begin
      @(negedge CLK);
      check({tag, "_hi"}, 32'(Tx_data), 32'(hi));
      check({tag, "_gap_novalid"}, 32'(Tx_valid), 32'd0);
      check({tag, "_grant_held"}, 32'(Req_grant), 32'(g));
      @(negedge CLK);
      check({tag, "_valid2"}, 32'(Tx_valid), 32'd1);
      Tx_busy = 1'b1;
      @(negedge CLK);
      check({tag, "_mid_nodone"}, 32'(Req_done), 32'd0);
      @(negedge CLK);
      Tx_busy = 1'b0;
      @(negedge CLK);
    end
    @(negedge CLK);
    check({tag, "_done"}, 32'(Req_done), 32'(g));
    check({tag, "_grant_clr"}, 32'(Req_grant), 32'd0);
    check({tag, "_idle"}, 32'(Sched_busy), 32'd0);
  endtask

  initial begin
    Reset    = 1'b0;
    Req      = '0;
    Req_len  = '0;
    Req_data = '0;
    Tx_busy  = 1'b0;

    repeat (2) @(negedge CLK);
    check("reset_outputs",
          32'({Tx_data, Tx_valid, Req_grant, Req_done, Sched_busy, Err_timeout}), 32'd0);
    Reset = 1'b1;
    @(negedge CLK);
    check("post_reset_idle", 32'(Sched_busy), 32'd0);

    // Single 1-byte transaction from requester 0.
    Req      = 2'b01;
    Req_len  = 2'b00;
    Req_data = {16'h0000, 16'h00A5};
    serve(2'b01, 1'b0, 8'hA5, 8'h00, 1'b0, "one_byte");
    Req = '0;
    @(negedge CLK);
    check("one_byte_done_pulse", 32'(Req_done), 32'd0);

    // 2-byte transaction from requester 1, low byte first.
    Req      = 2'b10;
    Req_len  = 2'b10;
    Req_data = {16'h1234, 16'h0000};
    serve(2'b10, 1'b1, 8'h34, 8'h12, 1'b0, "two_byte");
    Req = '0;
    @(negedge CLK);
    check("two_byte_done_pulse", 32'(Req_done), 32'd0);

    // Contention: both held, grants alternate starting with requester 0.
    Req      = 2'b11;
    Req_len  = 2'b00;
    Req_data = {16'h0022, 16'h0011};
    serve(2'b01, 1'b0, 8'h11, 8'h00, 1'b0, "rr0");
    serve(2'b10, 1'b0, 8'h22, 8'h00, 1'b0, "rr1");
    serve(2'b01, 1'b0, 8'h11, 8'h00, 1'b0, "rr2");
    serve(2'b10, 1'b0, 8'h22, 8'h00, 1'b0, "rr3");
    Req = '0;
    @(negedge CLK);

    // Timeout: Busy never rises, so the same byte is re-sent after 8 cycles.
    Req      = 2'b01;
    Req_len  = 2'b00;
    Req_data = {16'h0000, 16'h00C3};
    @(negedge CLK);
    @(negedge CLK);
    check("to_grant", 32'(Req_grant), 32'd1);
    @(negedge CLK);
    check("to_valid1", 32'(Tx_valid), 32'd1);
    repeat (7) @(negedge CLK);
    check("to_not_early", 32'(Err_timeout), 32'd0);
    @(negedge CLK);
    check("to_err", 32'(Err_timeout), 32'd1);
    check("to_err_novalid", 32'(Tx_valid), 32'd0);
    @(negedge CLK);
    check("to_retry_valid", 32'(Tx_valid), 32'd1);
    check("to_retry_data", 32'(Tx_data), 32'hC3);
    check("to_err_pulse", 32'(Err_timeout), 32'd0);
    Tx_busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    Tx_busy = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("to_done", 32'(Req_done), 32'd1);
    Req = '0;
    @(negedge CLK);

    // Reset during WAIT_FALL aborts at once; requester 0 wins afterwards.
    Req      = 2'b10;
    Req_len  = 2'b00;
    Req_data = {16'h0055, 16'h0077};
    @(negedge CLK);
    @(negedge CLK);
    check("rst_grant", 32'(Req_grant), 32'd2);
    @(negedge CLK);
    check("rst_valid", 32'(Tx_valid), 32'd1);
    Tx_busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("rst_async_outputs",
          32'({Tx_data, Tx_valid, Req_grant, Req_done, Sched_busy, Err_timeout}), 32'd0);
    Tx_busy = 1'b0;
    Req     = 2'b11;
    @(negedge CLK);
    check("rst_no_done", 32'(Req_done), 32'd0);
    Reset = 1'b1;
    serve(2'b01, 1'b0, 8'h77, 8'h00, 1'b0, "after_rst");

    // Payload, length and Req change after LOAD; latched values are sent.
    Req      = 2'b10;
    Req_len  = 2'b10;
    Req_data = {16'hBEEF, 16'h0000};
    serve(2'b10, 1'b1, 8'hEF, 8'hBE, 1'b1, "latched");
    Req = '0;
    repeat (3) @(negedge CLK);
    check("final_idle", 32'(Sched_busy), 32'd0);
    check("final_no_grant", 32'(Req_grant), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
